// File: rtl/hub75_pkg.sv
// Constants and types shared by the HUB75 framebuffer and the scan driver.
package hub75_pkg;

    localparam int PIXEL_COLUMNS = 64;
    localparam int PIXEL_LINES   = 16;
    localparam int COLOR_BITS    = 3;

    localparam int COL_W        = $clog2(PIXEL_COLUMNS);
    localparam int ROW_W        = $clog2(PIXEL_LINES);
    localparam int FRAME_PIXELS = 2 * PIXEL_LINES * PIXEL_COLUMNS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } load_state_e;

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM, one write port and one registered read port; the bank
// select is the address MSB. No reset on the array so it maps to block RAM.
module fb_bank_ram #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_loader.sv
// Double-buffered HUB75 framebuffer: loads a raster pixel stream into the back
// bank and swaps banks at a driver frame boundary once a full frame is present.
module frame_loader #(
    parameter int PIXEL_COLUMNS = hub75_pkg::PIXEL_COLUMNS,
    parameter int PIXEL_LINES   = hub75_pkg::PIXEL_LINES,
    parameter int COLOR_BITS    = hub75_pkg::COLOR_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [COLOR_BITS-1:0]            s_data,
    input  logic                             s_sof,
    input  logic [$clog2(PIXEL_COLUMNS)-1:0] rd_column,
    input  logic [$clog2(PIXEL_LINES)-1:0]   rd_addr,
    output logic [COLOR_BITS-1:0]            RGB0,
    output logic [COLOR_BITS-1:0]            RGB1,
    input  logic                             frame_end,
    output logic                             frame_pending,
    output logic                             sync_err
);
    import hub75_pkg::*;

    localparam int CW   = $clog2(PIXEL_COLUMNS);
    localparam int RW   = $clog2(PIXEL_LINES);
    localparam int NPIX = 2 * PIXEL_LINES * PIXEL_COLUMNS;
    localparam int PW   = $clog2(NPIX);
    localparam int AW   = 1 + RW + CW;

    load_state_e     state_q, state_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic            front_q, front_d;
    logic            shown_q, shown_d;
    logic            shown_rd_q, shown_rd_d;
    logic            s_ready_q, s_ready_d;
    logic            sync_err_q, sync_err_d;

    logic            xfer;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic [AW-1:0]   wr_ram_addr;
    logic [AW-1:0]   rd_ram_addr;
    logic [COLOR_BITS-1:0] upper_data, lower_data;

    assign xfer = s_valid & s_ready_q;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        front_d    = front_q;
        shown_d    = shown_q;
        sync_err_d = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = wptr_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (s_sof) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        wptr_d  = PW'(1);
                        state_d = LOAD;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    // A start-of-frame mid-load restarts the frame at pixel 0.
                    if (s_sof) begin
                        sync_err_d = 1'b1;
                        wr_idx     = '0;
                        wptr_d     = PW'(1);
                    end else if (wptr_q == PW'(NPIX - 1)) begin
                        wptr_d  = '0;
                        state_d = FULL;
                    end else begin
                        wptr_d = wptr_q + PW'(1);
                    end
                end
            end
            FULL: begin
                if (frame_end) begin
                    front_d = ~front_q;
                    shown_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d  = (state_d != FULL);
        // Mask follows the read it qualifies, so the bank read at the swap edge stays blank.
        shown_rd_d = shown_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            front_q    <= 1'b0;
            shown_q    <= 1'b0;
            shown_rd_q <= 1'b0;
            s_ready_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            front_q    <= front_d;
            shown_q    <= shown_d;
            shown_rd_q <= shown_rd_d;
            s_ready_q  <= s_ready_d;
            sync_err_q <= sync_err_d;
        end
    end

    // The pointer MSB selects the half: rows 0..LINES-1 upper, the rest lower.
    assign wr_ram_addr = {~front_q, wr_idx[PW-2:0]};
    assign rd_ram_addr = {front_q, rd_addr, rd_column};

    fb_bank_ram #(.DATA_W(COLOR_BITS), .ADDR_W(AW)) u_upper (
        .clk     (clk),
        .wr_en   (wr_en & ~wr_idx[PW-1]),
        .wr_addr (wr_ram_addr),
        .wr_data (s_data),
        .rd_addr (rd_ram_addr),
        .rd_data (upper_data)
    );

    fb_bank_ram #(.DATA_W(COLOR_BITS), .ADDR_W(AW)) u_lower (
        .clk     (clk),
        .wr_en   (wr_en & wr_idx[PW-1]),
        .wr_addr (wr_ram_addr),
        .wr_data (s_data),
        .rd_addr (rd_ram_addr),
        .rd_data (lower_data)
    );

    assign RGB0          = shown_rd_q ? upper_data : '0;
    assign RGB1          = shown_rd_q ? lower_data : '0;
    assign s_ready       = s_ready_q;
    assign sync_err      = sync_err_q;
    assign frame_pending = (state_q == FULL);

endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader against a frame-level reference model.
module tb_frame_loader;

    localparam int COLS = 64;
    localparam int LINES = 16;
    localparam int NPIX = 2 * LINES * COLS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [2:0] s_data = '0;
    logic       s_sof = 1'b0;
    logic [5:0] rd_column = '0;
    logic [3:0] rd_addr = '0;
    logic [2:0] RGB0, RGB1;
    logic       frame_end = 1'b0;
    logic       frame_pending;
    logic       sync_err;

    frame_loader dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_sof         (s_sof),
        .rd_column     (rd_column),
        .rd_addr       (rd_addr),
        .RGB0          (RGB0),
        .RGB1          (RGB1),
        .frame_end     (frame_end),
        .frame_pending (frame_pending),
        .sync_err      (sync_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame being assembled, frame on display, flags.
    logic [2:0] m_buf [NPIX];
    logic [2:0] m_disp [NPIX];
    logic [2:0] pat [NPIX];
    int   m_cnt = 0;
    bit   m_loading = 0, m_full = 0, m_shown = 0, m_ready = 0, m_sync = 0;
    bit   m_last_xfer = 0;
    logic [2:0] exp0 = '0, exp1 = '0;

    task automatic step(input bit r, input bit v, input bit sof, input logic [2:0] d,
                        input bit fe, input int col, input int row);
        bit xfer;
        @(negedge clk);
        rst = r; s_valid = v; s_sof = sof; s_data = d; frame_end = fe;
        rd_column = 6'(col); rd_addr = 4'(row);
        @(posedge clk);
        m_last_xfer = 0;
        if (r) begin
            exp0 = '0; exp1 = '0;
            m_loading = 0; m_full = 0; m_shown = 0; m_ready = 0; m_sync = 0; m_cnt = 0;
        end else begin
            exp0 = m_shown ? m_disp[row * COLS + col] : 3'd0;
            exp1 = m_shown ? m_disp[(row + LINES) * COLS + col] : 3'd0;
            xfer = v && m_ready;
            m_last_xfer = xfer;
            m_sync = 0;
            if (m_full) begin
                if (fe) begin
                    for (int i = 0; i < NPIX; i++) m_disp[i] = m_buf[i];
                    m_shown = 1; m_full = 0;
                end
            end else if (xfer) begin
                if (sof) begin
                    if (m_loading) m_sync = 1;
                    m_buf[0] = d; m_cnt = 1; m_loading = 1;
                end else if (!m_loading) begin
                    m_sync = 1;
                end else begin
                    m_buf[m_cnt] = d;
                    m_cnt++;
                    if (m_cnt == NPIX) begin
                        m_full = 1; m_loading = 0; m_cnt = 0;
                    end
                end
            end
            m_ready = !m_full;
        end
        #1;
        check("s_ready", s_ready, m_ready);
        check("frame_pending", frame_pending, m_full);
        check("sync_err", sync_err, m_sync);
        check("rgb0", RGB0, exp0);
        check("rgb1", RGB1, exp1);
    endtask

    task automatic fill_pat(input bit rnd);
        for (int p = 0; p < NPIX; p++) pat[p] = rnd ? 3'($urandom) : 3'(p % 8);
    endtask

    task automatic feed(input int first, input int n, input bit fe_last);
        for (int p = first; p < first + n; p++)
            step(0, 1, p == 0, pat[p], fe_last && (p == first + n - 1),
                 $urandom_range(0, COLS - 1), $urandom_range(0, LINES - 1));
    endtask

    task automatic idle(input int n, input bit fe_first);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 3'd0, fe_first && i == 0,
                 $urandom_range(0, COLS - 1), $urandom_range(0, LINES - 1));
    endtask

    task automatic sweep();
        for (int a = 0; a < COLS * LINES; a++) step(0, 0, 0, 3'd0, 0, a % COLS, a / COLS);
    endtask

    initial begin
        int  gen_idx;
        bit  did_rst;
        bit  v;

        // Reset, then blank output everywhere.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 3'd0, 0, 0, 0);
        check("ready_in_reset", s_ready, 1'b0);
        sweep();
        check("ready_after_reset", s_ready, 1'b1);

        // Stray pixel while idle is discarded with an error pulse.
        step(0, 1, 0, 3'd7, 0, 0, 0);
        check("idle_no_sof_err", sync_err, 1'b1);

        // Frame p%8, then swap and read everything back.
        fill_pat(0);
        feed(0, NPIX, 0);
        idle(20, 0);
        check("pending_before_swap", frame_pending, 1'b1);
        idle(1, 1);
        step(0, 0, 0, 3'd0, 0, 5, 3);
        check("rgb0_r3c5", RGB0, 3'd5);
        check("rgb1_r3c5", RGB1, 3'd5);
        sweep();

        // Full frame with no frame_end: stays pending, old frame still shown.
        fill_pat(1);
        feed(0, NPIX, 0);
        idle(100, 0);
        check("held_pending", frame_pending, 1'b1);
        check("held_ready", s_ready, 1'b0);
        idle(1, 1);
        idle(64, 0);

        // frame_end coincident with the last pixel does not swap.
        fill_pat(1);
        feed(0, NPIX, 1);
        idle(30, 0);
        check("coincident_no_swap", frame_pending, 1'b1);
        idle(1, 1);
        idle(64, 0);

        // Restart on a second start-of-frame at pixel 700.
        fill_pat(1);
        feed(0, 700, 0);
        fill_pat(1);
        feed(0, 1, 0);
        check("restart_sync_err", sync_err, 1'b1);
        feed(1, NPIX - 2, 0);
        check("restart_not_full", frame_pending, 1'b0);
        feed(NPIX - 1, 1, 0);
        check("restart_full", frame_pending, 1'b1);
        idle(1, 1);
        idle(64, 0);

        // Random traffic with periodic frame_end and one reset mid-load.
        gen_idx = 0;
        did_rst = 0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            bit r;
            r = 0;
            if (!did_rst && cyc > 3000 && m_loading && m_cnt > 300) begin
                r = 1; did_rst = 1;
            end
            v = ($urandom_range(0, 9) < 7);
            step(r, v, gen_idx == 0, 3'($urandom), (cyc % 500) == 499,
                 $urandom_range(0, COLS - 1), $urandom_range(0, LINES - 1));
            if (r) gen_idx = 0;
            else if (m_last_xfer) gen_idx = (gen_idx + 1) % NPIX;
            if (r) begin
                idle(3, 0);
                check("blank_after_rst", RGB0, 3'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
